// File: rtl/rst_sync_pkg.sv
// Shared constants for the reset synchronizer.
package rst_sync_pkg;

   localparam int unsigned RST_SYNC_MIN_STAGES = 2;
   localparam int unsigned RST_SYNC_DEF_STAGES = 2;

endpackage : rst_sync_pkg

// File: rtl/rst_sync_stage.sv
// One synchronizer flop with synchronous active-low clear.
module rst_sync_stage (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic q_d;
   (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic q_q;

   always_comb begin
      q_d = 1'b0;
      if (rst_n) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;

endmodule : rst_sync_stage

// File: rtl/rst_sync.sv
// Reset synchronizer: SYNC_RST asserts one edge after RST is sampled low and
// releases after NUM_STAGES consecutive edges sample RST high.
module rst_sync
   import rst_sync_pkg::*;
#(
   parameter int unsigned NUM_STAGES = RST_SYNC_DEF_STAGES
) (
   input  logic CLK,
   input  logic RST,
   output logic SYNC_RST
);

   logic [NUM_STAGES-1:0] sync_chain;

   if (NUM_STAGES < RST_SYNC_MIN_STAGES) begin : g_bad_stages
      $error("rst_sync: NUM_STAGES must be >= 2");
   end

   // Stage 0 shifts in a constant one; every stage clears while RST is low.
   for (genvar i = 0; i < int'(NUM_STAGES); i++) begin : g_stage
      logic stage_d;
      if (i == 0) begin : g_first
         assign stage_d = 1'b1;
      end else begin : g_next
         assign stage_d = sync_chain[i-1];
      end
      rst_sync_stage u_stage (
         .clk   (CLK),
         .rst_n (RST),
         .d     (stage_d),
         .q     (sync_chain[i])
      );
   end

   assign SYNC_RST = sync_chain[NUM_STAGES-1];

`ifdef RST_SYNC_SVA
   a_assert_on_low : assert property (@(posedge CLK) !RST |=> !SYNC_RST);
   for (genvar k = 1; k <= int'(NUM_STAGES); k++) begin : g_sva_rel
      a_release_needs_high : assert property (@(posedge CLK) $rose(SYNC_RST) |-> $past(RST, k));
   end
`endif

endmodule : rst_sync

// File: tb/tb_rst_sync.sv
// Bench for rst_sync: NUM_STAGES=2 and NUM_STAGES=4 instances share one RST.
module tb_rst_sync;

   logic clk;
   logic rst;
   logic sync_rst_2;
   logic sync_rst_4;

   rst_sync #(.NUM_STAGES(2)) u_dut2 (.CLK(clk), .RST(rst), .SYNC_RST(sync_rst_2));
   rst_sync #(.NUM_STAGES(4)) u_dut4 (.CLK(clk), .RST(rst), .SYNC_RST(sync_rst_4));

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {
      bit    rst;
      bit    exp2;
      bit    exp4;
      string name;
   } vec_t;

   typedef struct {
      bit    exp2;
      bit    exp4;
      string name;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks;
   int  n_fail;
   int  hi_cnt;

   // Pop one expectation and compare both instances.
   task automatic check_one();
      sb_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e = sb_q.pop_front();
      n_checks++;
      if (sync_rst_2 !== e.exp2) begin
         n_fail++;
         $display("FAIL %s n2: got %b want %b at %0t", e.name, sync_rst_2, e.exp2, $time);
      end
      n_checks++;
      if (sync_rst_4 !== e.exp4) begin
         n_fail++;
         $display("FAIL %s n4: got %b want %b at %0t", e.name, sync_rst_4, e.exp4, $time);
      end
   endtask

   // Drive one edge with expectations given explicitly.
   task automatic cycle_exp(input bit r, input bit e2, input bit e4, input string name);
      sb_t e;
      rst = r;
      hi_cnt = r ? hi_cnt + 1 : 0;
      e.exp2 = e2;
      e.exp4 = e4;
      e.name = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_one();
   endtask

   // Drive one edge with expectations from the consecutive-high counter model.
   task automatic cycle(input bit r, input string name);
      int c;
      c = r ? hi_cnt + 1 : 0;
      cycle_exp(r, c >= 2, c >= 4, name);
   endtask

   vec_t vecs[$];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      hi_cnt   = 0;
      rst      = 1'b0;

      // Case 1 power-up and case 3 long reset, hand-derived expectations.
      vecs.push_back('{1'b0, 1'b0, 1'b0, "pwr_low"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, "pwr_hi1"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, "pwr_hi2"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, "pwr_hi3"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, "pwr_hi4"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, "pwr_steady"});
      for (int i = 0; i < 10; i++) vecs.push_back('{1'b0, 1'b0, 1'b0, "long_low"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, "long_hi1"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, "long_hi2"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, "long_hi3"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, "long_hi4"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, "long_steady"});

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         cycle_exp(vecs[i].rst, vecs[i].exp2, vecs[i].exp4, vecs[i].name);
      end

      // Case 2/6: single-edge low pulse, four times back to back.
      for (int p = 0; p < 4; p++) begin
         cycle(1'b0, "pulse_low");
         for (int j = 0; j < 5; j++) cycle(1'b1, "pulse_hi");
      end

      // Case 4: re-assert while the chain is filling.
      cycle(1'b0, "rearm_low1");
      cycle(1'b1, "rearm_hi1");
      cycle(1'b0, "rearm_low2");
      for (int j = 0; j < 6; j++) cycle(1'b1, "rearm_hi");

      // Case 5: 20 ns glitch between edges is never sampled.
      for (int g = 0; g < 3; g++) begin
         sb_t e;
         e.exp2 = 1'b1;
         e.exp4 = 1'b1;
         e.name = "glitch";
         sb_q.push_back(e);
         #30 rst = 1'b0;
         #20 rst = 1'b1;
         @(posedge clk);
         #1;
         check_one();
      end

      // Random tail against the counter model.
      for (int j = 0; j < 60; j++) begin
         cycle(($urandom_range(0, 3) != 0), "random");
      end

      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Any edge sampling RST low must leave both outputs low.
   always @(posedge clk) begin
      if (rst === 1'b0) begin
         #1;
         n_checks++;
         if (sync_rst_2 !== 1'b0 || sync_rst_4 !== 1'b0) begin
            n_fail++;
            $display("FAIL low_forces_zero: got %b%b want 00 at %0t", sync_rst_2, sync_rst_4, $time);
         end
      end
   end

endmodule : tb_rst_sync
